// File: rtl/packet_rr_arbiter_if.sv
// Signal bundle between the upstream packet FIFOs, the packet round-robin arbiter and the
// shared downstream consumer. The master view is the arbiter itself.
interface packet_rr_arbiter_if #(
    parameter int unsigned NUM_PORTS  = 4,
    parameter int unsigned DATA_WIDTH = 32
);
    localparam int unsigned PORT_W = $clog2(NUM_PORTS);

    logic [NUM_PORTS-1:0]            in_pkt_rdy;
    logic [NUM_PORTS-1:0]            in_data_vld;
    logic [NUM_PORTS*DATA_WIDTH-1:0] in_data;
    logic [NUM_PORTS-1:0]            in_ren;
    logic [DATA_WIDTH-1:0]           out_data;
    logic                            out_valid;
    logic                            out_ready;
    logic [PORT_W-1:0]               out_port;
    logic                            busy;
    logic                            err;

    modport master (
        input  in_pkt_rdy,
        input  in_data_vld,
        input  in_data,
        input  out_ready,
        output in_ren,
        output out_data,
        output out_valid,
        output out_port,
        output busy,
        output err
    );

    modport slave (
        output in_pkt_rdy,
        output in_data_vld,
        output in_data,
        output out_ready,
        input  in_ren,
        input  out_data,
        input  out_valid,
        input  out_port,
        input  busy,
        input  err
    );
endinterface

// File: rtl/packet_rr_arbiter.sv
// Packet-level round-robin arbiter: drains fwft packet FIFOs (word MSB = eop) into one stream,
// holding the grant for a whole packet and cutting packets that exceed MAX_PKT_LEN beats.
module packet_rr_arbiter #(
    parameter int unsigned NUM_PORTS   = 4,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned MAX_PKT_LEN = 256
) (
    input logic                 clk,
    input logic                 rst,
    packet_rr_arbiter_if.master bus
);
    localparam int unsigned PORT_W = $clog2(NUM_PORTS);
    localparam int unsigned CNT_W  = $clog2(MAX_PKT_LEN + 1);
    localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(MAX_PKT_LEN - 1);
    localparam logic [PORT_W-1:0] LAST_PORT = PORT_W'(NUM_PORTS - 1);

    typedef enum logic [0:0] {StIdle, StBusy} state_e;

    state_e                state_q, state_d;
    logic [PORT_W-1:0]     grant_q, grant_d;
    logic [PORT_W-1:0]     last_grant_q, last_grant_d;
    logic [CNT_W-1:0]      beat_cnt_q, beat_cnt_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                  out_valid_q, out_valid_d;
    logic [PORT_W-1:0]     out_port_q, out_port_d;
    logic                  err_q, err_d;

    logic [PORT_W-1:0]     pick;
    logic                  pick_vld;
    int unsigned           cand;
    logic [DATA_WIDTH-1:0] head;
    logic                  head_vld;
    logic                  rd;
    logic                  eop;
    logic                  wd_hit;
    logic [NUM_PORTS-1:0]  ren;

    // Round-robin search starting just after the last served port.
    always_comb begin
        pick     = '0;
        pick_vld = 1'b0;
        cand     = 0;
        for (int unsigned k = 1; k <= NUM_PORTS; k++) begin
            cand = 32'(last_grant_q) + k;
            if (cand >= NUM_PORTS) begin
                cand = cand - NUM_PORTS;
            end
            if (!pick_vld && bus.in_pkt_rdy[cand[PORT_W-1:0]]) begin
                pick_vld = 1'b1;
                pick     = cand[PORT_W-1:0];
            end
        end
    end

    always_comb begin
        head     = '0;
        head_vld = 1'b0;
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            if (grant_q == PORT_W'(p)) begin
                head     = bus.in_data[p*DATA_WIDTH +: DATA_WIDTH];
                head_vld = bus.in_data_vld[p];
            end
        end
    end

    // A read may only happen when the output register is free or being drained this cycle.
    assign rd     = (state_q == StBusy) && head_vld && (!out_valid_q || bus.out_ready);
    assign eop    = head[DATA_WIDTH-1];
    assign wd_hit = (beat_cnt_q == LAST_BEAT);

    always_comb begin
        ren = '0;
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            ren[p] = rd && (grant_q == PORT_W'(p));
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        beat_cnt_d   = beat_cnt_q;
        out_data_d   = out_data_q;
        out_valid_d  = out_valid_q;
        out_port_d   = out_port_q;
        err_d        = err_q;

        if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            StIdle: begin
                if (pick_vld) begin
                    grant_d = pick;
                    state_d = StBusy;
                end
            end
            StBusy: begin
                if (rd) begin
                    out_data_d                 = head;
                    out_data_d[DATA_WIDTH-1]   = eop | wd_hit;
                    out_valid_d                = 1'b1;
                    out_port_d                 = grant_q;
                    if (eop || wd_hit) begin
                        state_d      = StIdle;
                        last_grant_d = grant_q;
                        beat_cnt_d   = '0;
                        // Forced termination of an over-long packet is recorded until reset.
                        if (!eop) begin
                            err_d = 1'b1;
                        end
                    end else begin
                        beat_cnt_d = beat_cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            grant_q      <= '0;
            last_grant_q <= LAST_PORT;
            beat_cnt_q   <= '0;
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
            out_port_q   <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            beat_cnt_q   <= beat_cnt_d;
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
            out_port_q   <= out_port_d;
            err_q        <= err_d;
        end
    end

    assign bus.in_ren    = ren;
    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_port  = out_port_q;
    assign bus.busy      = (state_q == StBusy);
    assign bus.err       = err_q;

endmodule

// File: tb/tb_packet_rr_arbiter.sv
// Bench for packet_rr_arbiter: emulates fwft packet FIFOs and predicts the output stream with a
// packet-level round-robin model.
module tb_packet_rr_arbiter;
    localparam int unsigned NP     = 4;
    localparam int unsigned DW     = 32;
    localparam int unsigned MAXLEN = 8;
    localparam int unsigned PW     = $clog2(NP);

    typedef struct {
        int port;
        bit last;
        bit wd;
    } rd_t;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    packet_rr_arbiter_if #(.NUM_PORTS(NP), .DATA_WIDTH(DW)) bus ();

    packet_rr_arbiter #(
        .NUM_PORTS  (NP),
        .DATA_WIDTH (DW),
        .MAX_PKT_LEN(MAXLEN)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;

    logic [DW-1:0]    fifo [NP][$];
    logic [DW-1:0]    mq   [NP][$];
    logic [PW+DW-1:0] exp_out [$];
    rd_t              exp_rd [$];
    int               grant_log [$];
    int               model_last;
    int               rd_count;

    logic             out_ready_k;
    logic [NP-1:0]    stall;
    logic [NP-1:0]    rdy_kill;
    logic [NP-1:0]    ren_s;
    bit               mon_en;
    bit               exp_err;
    bit               exp_ov_next;
    bit               exp_busy_next;
    bit               hold_prev;
    bit               unit_start;
    bit               last_ov;
    bit               last_bz;
    logic [DW-1:0]    prev_od;
    logic [PW-1:0]    prev_op;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_pkt(input int port, input int len);
        logic [DW-1:0] w;
        for (int j = 0; j < len; j++) begin
            w         = $urandom;
            w[DW-1]   = (j == len - 1);
            fifo[port].push_back(w);
        end
    endtask

    // Packet-level model: serve ports round robin, each turn taking one packet or MAXLEN beats.
    task automatic start_phase();
        int p;
        logic [DW-1:0] w;
        bit e;
        bit cut;
        rd_t r;
        rd_count = 0;
        grant_log.delete();
        for (int i = 0; i < NP; i++) mq[i] = fifo[i];
        while (1) begin
            p = -1;
            for (int k = 1; k <= NP; k++) begin
                if (p < 0 && mq[(model_last + k) % NP].size() != 0) p = (model_last + k) % NP;
            end
            if (p < 0) break;
            for (int n = 1; n <= MAXLEN; n++) begin
                w   = mq[p].pop_front();
                e   = w[DW-1];
                cut = !e && (n == MAXLEN);
                if (cut) w[DW-1] = 1'b1;
                exp_out.push_back({PW'(p), w});
                r.port = p;
                r.last = e || cut;
                r.wd   = cut;
                exp_rd.push_back(r);
                if (e || cut || mq[p].size() == 0) break;
            end
            model_last = p;
        end
    endtask

    task automatic drive();
        for (int i = 0; i < NP; i++) begin
            bus.in_data_vld[i] = (fifo[i].size() != 0) && !stall[i];
            bus.in_pkt_rdy[i]  = (fifo[i].size() != 0) && !rdy_kill[i];
            if (fifo[i].size() != 0) bus.in_data[i*DW +: DW] = fifo[i][0];
            else bus.in_data[i*DW +: DW] = '0;
        end
        bus.out_ready = out_ready_k;
    endtask

    task automatic monitor();
        logic [NP-1:0] ren;
        logic [NP-1:0] exp_ren;
        logic          ov;
        logic          bz;
        logic          ordy;
        logic [DW-1:0] od;
        logic [PW-1:0] op;
        logic [PW+DW-1:0] e;
        bit            rd_exp;
        int            g;
        rd_t           r;
        ren  = bus.in_ren;
        ov   = bus.out_valid;
        bz   = bus.busy;
        od   = bus.out_data;
        op   = bus.out_port;
        ordy = bus.out_ready;
        check("busy", bz, exp_busy_next);
        check("out_valid", ov, exp_ov_next);
        if (hold_prev) begin
            check("hold_data", od, prev_od);
            check("hold_port", op, prev_op);
        end
        check("err", bus.err, exp_err);
        exp_ren = '0;
        rd_exp  = 1'b0;
        if (bz && exp_rd.size() != 0) begin
            g      = exp_rd[0].port;
            rd_exp = bus.in_data_vld[g] && (!ov || ordy);
            if (rd_exp) exp_ren[g] = 1'b1;
        end
        check("in_ren", ren, exp_ren);
        if (ov && ordy) begin
            check("spare_beat", 64'(exp_out.size() == 0), 64'd0);
            if (exp_out.size() != 0) begin
                e = exp_out.pop_front();
                check("beat_port", op, e[PW+DW-1:DW]);
                check("beat_data", od, e[DW-1:0]);
            end
        end
        if (rd_exp) begin
            r = exp_rd.pop_front();
            rd_count++;
            if (unit_start) grant_log.push_back(r.port);
            unit_start    = r.last;
            exp_busy_next = !r.last;
            if (r.wd) exp_err = 1'b1;
        end else begin
            exp_busy_next = bz ? 1'b1 : (|bus.in_pkt_rdy);
        end
        exp_ov_next = rd_exp || (ov && !ordy);
        hold_prev   = ov && !ordy;
        prev_od     = od;
        prev_op     = op;
        last_ov     = ov;
        last_bz     = bz;
    endtask

    task automatic cycle();
        drive();
        @(negedge clk);
        ren_s = bus.in_ren;
        if (mon_en) monitor();
        @(posedge clk);
        #1;
        for (int i = 0; i < NP; i++) begin
            if (ren_s[i] && fifo[i].size() != 0) void'(fifo[i].pop_front());
        end
    endtask

    function automatic bit phase_done();
        return exp_rd.size() == 0 && exp_out.size() == 0 && !last_ov && !last_bz;
    endfunction

    task automatic run_phase(input int mode);
        int k;
        k = 0;
        while (!phase_done() && k < 3000) begin
            out_ready_k = 1'b1;
            stall       = '0;
            rdy_kill    = '0;
            case (mode)
                1: rdy_kill[0] = (k >= 1);
                3: out_ready_k = !(k >= 4 && k <= 8);
                5: stall[3] = (k >= 3 && k <= 6);
                9: begin
                    out_ready_k = ($urandom_range(0, 3) != 0);
                    for (int i = 0; i < NP; i++) stall[i] = ($urandom_range(0, 4) == 0);
                end
                default: ;
            endcase
            cycle();
            k++;
        end
        out_ready_k = 1'b1;
        stall       = '0;
        rdy_kill    = '0;
        check("phase_drained", phase_done(), 1);
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        mon_en = 1'b0;
        cycle();
        for (int i = 0; i < NP; i++) fifo[i].delete();
        exp_out.delete();
        exp_rd.delete();
        model_last    = NP - 1;
        exp_err       = 1'b0;
        exp_ov_next   = 1'b0;
        exp_busy_next = 1'b0;
        hold_prev     = 1'b0;
        unit_start    = 1'b1;
        last_ov       = 1'b0;
        last_bz       = 1'b0;
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_data", bus.out_data, 0);
        check("rst_out_port", bus.out_port, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_err", bus.err, 0);
        check("rst_in_ren", bus.in_ren, 0);
        rst    = 1'b0;
        mon_en = 1'b1;
    endtask

    initial begin
        int exp_order [5];
        int k;
        rst         = 1'b1;
        out_ready_k = 1'b1;
        stall       = '0;
        rdy_kill    = '0;
        mon_en      = 1'b0;
        ren_s       = '0;
        rd_count    = 0;
        do_reset();

        // Single 3-beat packet on port 0; its request drops once granted.
        push_pkt(0, 3);
        start_phase();
        run_phase(1);
        check("t1_reads", rd_count, 3);
        check("t1_grants", grant_log.size(), 1);
        check("t1_port", grant_log[0], 0);

        // All four ports, two 2-beat packets each.
        do_reset();
        for (int i = 0; i < NP; i++) begin
            push_pkt(i, 2);
            push_pkt(i, 2);
        end
        start_phase();
        run_phase(0);
        exp_order = '{0, 1, 2, 3, 0};
        for (int i = 0; i < 5; i++) check("t2_order", grant_log[i], exp_order[i]);

        // Output back-pressure mid-packet.
        push_pkt(1, 6);
        start_phase();
        run_phase(3);
        check("t3_reads", rd_count, 6);

        // Source underrun mid-packet.
        push_pkt(3, 6);
        start_phase();
        run_phase(5);
        check("t5_reads", rd_count, 6);

        // Over-long packet on port 2 is cut at MAXLEN; port 3 must be served next.
        push_pkt(2, 12);
        push_pkt(3, 2);
        start_phase();
        run_phase(0);
        check("t4_grants", grant_log.size(), 3);
        check("t4_first", grant_log[0], 2);
        check("t4_second", grant_log[1], 3);
        check("t4_err", bus.err, 1);

        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < NP; i++) begin
                for (int n = $urandom_range(0, 2); n > 0; n--) push_pkt(i, $urandom_range(1, 11));
            end
            start_phase();
            run_phase(9);
        end

        // Reset while port 1 is mid-packet, then port 0 must win.
        push_pkt(1, 5);
        start_phase();
        k = 0;
        while (rd_count < 1 && k < 50) begin
            cycle();
            k++;
        end
        check("t6_started", rd_count, 1);
        do_reset();
        push_pkt(0, 2);
        push_pkt(1, 2);
        start_phase();
        run_phase(0);
        check("t6_first", grant_log[0], 0);
        check("t6_second", grant_log[1], 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/packet_rr_arbiter.md
Name: packet_rr_arbiter

Overview:
- Packet-level round-robin arbiter. It drains NUM_PORTS upstream packet FIFOs (fwft, MSB of each word = eop) into one output stream.
- Grant is locked to one port from the first beat of a packet until its eop beat, so packets are never interleaved.
- Sits between per-channel packet FIFOs and a shared downstream consumer (DMA or egress datapath).
- Includes a max-packet-length watchdog with sticky error.

Parameters:
- NUM_PORTS, 4, number of requesting FIFOs (>=2).
- DATA_WIDTH, 32, word width; bit DATA_WIDTH-1 is eop.
- MAX_PKT_LEN, 256, max beats per packet before forced termination.
- PORT_W (localparam), $clog2(NUM_PORTS), grant index width.

Ports:
- clk, input, 1, single clock.
- rst, input, 1, reset; synchronous to clk, active-high.
- in_pkt_rdy, input, NUM_PORTS, bit i = FIFO i holds at least one complete packet.
- in_data_vld, input, NUM_PORTS, bit i = FIFO i fwft word valid (not empty).
- in_data, input, NUM_PORTS*DATA_WIDTH, fwft head word of FIFO i in slice [i*DATA_WIDTH +: DATA_WIDTH].
- in_ren, output, NUM_PORTS, read strobe per FIFO; one-hot or zero.
- out_data, output, DATA_WIDTH, registered output word.
- out_valid, output, 1, out_data valid.
- out_ready, input, 1, downstream accepts word when out_valid && out_ready.
- out_port, output, PORT_W, source port of out_data.
- busy, output, 1, high while a packet is granted (state BUSY).
- err, output, 1, sticky watchdog error.

Behaviour:
- Reset values (rst high at posedge):
  - out_valid=0, out_data=0, out_port=0, busy=0, err=0, state=IDLE, beat_cnt=0.
  - last_grant=NUM_PORTS-1, so port 0 has first priority.
  - in_ren=0 (combinational, forced 0 in IDLE).
- State IDLE:
  - If any in_pkt_rdy bit is set, pick the first set index searching last_grant+1 .. last_grant+NUM_PORTS (mod NUM_PORTS).
  - Register it as grant and go to BUSY next cycle.
  - No read happens in IDLE, so there is exactly one bubble cycle between packets.
- State BUSY:
  - in_ren[grant] = in_data_vld[grant] && (!out_valid || out_ready). All other in_ren bits are 0.
  - On in_ren: out_data <= in_data[grant]; out_port <= grant; out_valid <= 1; beat_cnt++.
  - With out_valid && out_ready and no new read: out_valid <= 0. out_data holds its last value.
- End of packet:
  - A read whose word MSB=1 returns to IDLE; last_grant <= grant; beat_cnt <= 0.
- Watchdog:
  - If the read making beat_cnt == MAX_PKT_LEN has MSB=0, force out_data MSB=1 on that beat.
  - Then set err=1, return to IDLE and set last_grant <= grant.
  - The remaining words of that packet are forwarded as a new packet on a later grant; this is a downstream concern.
  - err clears only on rst.
- Stall conditions:
  - in_data_vld[grant]=0 in BUSY stalls with no read and no output change.
  - out_ready=0 with out_valid=1 holds out_data and out_port stable and suppresses in_ren.
- Sampling rules:
  - in_pkt_rdy is sampled only in IDLE; changes during BUSY are ignored.
  - A requester granted while its in_pkt_rdy deasserts the next cycle is still served (packet guaranteed present).
- Throughput: one beat per cycle while out_ready=1 and data is valid; latency is in_ren to out_valid = 1 cycle.
- beat_cnt width: $clog2(MAX_PKT_LEN+1); saturation is unreachable because of the watchdog.
- Reset mid-packet: everything returns to reset values next cycle and the partial packet is abandoned. Upstream FIFOs share rst.
- Simultaneous events: an eop read with out_ready=1 in the same cycle is accepted normally; the next grant is evaluated in the following IDLE cycle.

Test Plan:
1. Only port 0 ready, 3-beat packet, out_ready=1.
   -> IDLE 1 cycle, in_ren[0] high 3 consecutive cycles, out_valid 3 cycles, out_port=0, last out_data MSB=1, busy falls after eop.
2. Ports 0-3 all ready, 2-beat packets each, refilled continuously.
   -> grant order 0,1,2,3,0; exactly 1 idle cycle between packets; in_ren always one-hot or zero.
3. Port 1 packet of 6 beats, out_ready=0 for cycles 3-7 after first beat.
   -> in_ren[1]=0 during stall, out_data stable, all 6 words delivered once in order.
4. MAX_PKT_LEN=8, port 2 supplies 10 beats with no eop.
   -> 8 beats output, 8th has MSB forced 1, err=1 next cycle and remains 1, arbiter back in IDLE, last_grant=2.
5. Port 3 granted, in_data_vld[3] low for 4 cycles mid-packet.
   -> no in_ren, out_valid drops after the last word is accepted, packet resumes with no gaps or duplicates.
6. rst asserted during beat 2 of a 5-beat port-1 packet.
   -> next cycle all outputs 0, busy=0, err=0; with ports 0 and 1 ready afterwards, port 0 is granted first.
